// File: rtl/fp_mux_share_arbiter.sv
// fp_mux_share_arbiter
// Round-robin arbiter that shares one multi-cycle mantissa unit between two
// requesters. The winning operand is registered and presented to the unit
// through a 2:1 operand mux. The unit is started with a single pulse, the
// block waits for done, and the result is returned tagged with the owner id.
//
// Optional feature: define FPA_TIMEOUT_EN to enable a WAIT watchdog. After
// TIMEOUT cycles in WAIT without unit_done, the block raises a sticky err and
// returns an all-ones response. Without the macro, err is tied low and WAIT
// waits indefinitely.

module fp_mux_share_arbiter #(
    parameter int WIDTH   = 27,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req_0_valid,
    input  logic [WIDTH-1:0] req_0_data,
    output logic             req_0_ready,

    input  logic             req_1_valid,
    input  logic [WIDTH-1:0] req_1_data,
    output logic             req_1_ready,

    output logic             mux_select,
    output logic [WIDTH-1:0] unit_operand,
    output logic             unit_start,
    input  logic             unit_done,
    input  logic [WIDTH-1:0] unit_result,

    output logic             resp_valid,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_data,
    input  logic             resp_ready,

    output logic             busy,
    output logic             err
);

    // The watchdog compares against TIMEOUT-1, so it needs at least 2.
    if (TIMEOUT < 2) begin : g_timeout_check
        $error("fp_mux_share_arbiter: TIMEOUT must be at least 2");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic             last_grant_q, last_grant_d;  // id of the last completed owner
    logic             grant_q, grant_d;            // id of the current owner
    logic             mux_sel_q, mux_sel_d;
    logic [WIDTH-1:0] operand_q, operand_d;
    logic             resp_id_q, resp_id_d;
    logic [WIDTH-1:0] resp_data_q, resp_data_d;

    logic             pick_0;
    logic             pick_1;
    logic             grant_valid;
    logic             grant_id;

    // Round-robin pick: a lone requester always wins; on a tie the requester
    // that was not served last wins. Only meaningful while IDLE.
    always_comb begin
        pick_0      = req_0_valid && (!req_1_valid || last_grant_q);
        pick_1      = req_1_valid && (!req_0_valid || !last_grant_q);
        grant_valid = pick_0 || pick_1;
        grant_id    = pick_1;
    end

`ifdef FPA_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             err_q, err_d;
`endif

    // Next-state and datapath update for the arbitration FSM.
    always_comb begin
        // NOTE: every signal assigned in this block gets a default first, so
        // no path through the case leaves one unassigned and no latch appears.
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        mux_sel_d    = mux_sel_q;
        operand_d    = operand_q;
        resp_id_d    = resp_id_q;
        resp_data_d  = resp_data_q;
`ifdef FPA_TIMEOUT_EN
        wait_cnt_d   = wait_cnt_q;
        err_d        = err_q;
`endif

        case (state_q)
            ST_IDLE: begin
                // Accept and latch in the same cycle as the ready pulse; the
                // mux select follows the new owner from START onwards.
                if (grant_valid) begin
                    grant_d   = grant_id;
                    mux_sel_d = grant_id;
                    operand_d = grant_id ? req_1_data : req_0_data;
                    state_d   = ST_START;
                end
            end

            ST_START: begin
`ifdef FPA_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                // unit_done is only honoured here; pulses in other states
                // are stale or spurious and are dropped.
                if (unit_done) begin
                    resp_data_d = unit_result;
                    resp_id_d   = grant_q;
                    state_d     = ST_RESP;
                end
`ifdef FPA_TIMEOUT_EN
                else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d       = 1'b1;
                    resp_data_d = '1;
                    resp_id_d   = grant_q;
                    state_d     = ST_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
`endif
            end

            ST_RESP: begin
                // The priority pointer only moves once the owner's response
                // has actually been consumed.
                if (resp_ready) begin
                    last_grant_d = grant_q;
                    state_d      = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears every visible output and
    // points the priority at requester 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: all registers here are plain flops (no memory arrays), so
        // each one is reset; non-blocking assignments keep the update order
        // independent of statement order.
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            mux_sel_q    <= 1'b0;
            operand_q    <= '0;
            resp_id_q    <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            mux_sel_q    <= mux_sel_d;
            operand_q    <= operand_d;
            resp_id_q    <= resp_id_d;
            resp_data_q  <= resp_data_d;
        end
    end

`ifdef FPA_TIMEOUT_EN
    // Watchdog counter and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Outputs: the ready pulses are combinational from state and valids, the
    // rest are decoded from the state or driven straight from registers.
    always_comb begin
        req_0_ready  = (state_q == ST_IDLE) && pick_0;
        req_1_ready  = (state_q == ST_IDLE) && pick_1;
        unit_start   = (state_q == ST_START);
        resp_valid   = (state_q == ST_RESP);
        busy         = (state_q != ST_IDLE);
        mux_select   = mux_sel_q;
        unit_operand = operand_q;
        resp_id      = resp_id_q;
        resp_data    = resp_data_q;
    end

endmodule

// File: tb/tb_fp_mux_share_arbiter.sv
// Self-checking bench for fp_mux_share_arbiter: a table of whole transactions,
// hand-written reset / timeout sequences, and a randomized phase compared
// against a transaction-level reference model.

module tb_fp_mux_share_arbiter;

    localparam int W   = 27;
    localparam int TO  = 8;
    localparam int N_RANDOM = 3000;

    logic         clk;
    logic         rst_n;
    logic         req_0_valid, req_1_valid;
    logic [W-1:0] req_0_data, req_1_data;
    logic         req_0_ready, req_1_ready;
    logic         mux_select;
    logic [W-1:0] unit_operand;
    logic         unit_start;
    logic         unit_done;
    logic [W-1:0] unit_result;
    logic         resp_valid;
    logic         resp_id;
    logic [W-1:0] resp_data;
    logic         resp_ready;
    logic         busy;
    logic         err;

    int n_cmp = 0;
    int n_bad = 0;

    fp_mux_share_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_0_valid  (req_0_valid),
        .req_0_data   (req_0_data),
        .req_0_ready  (req_0_ready),
        .req_1_valid  (req_1_valid),
        .req_1_data   (req_1_data),
        .req_1_ready  (req_1_ready),
        .mux_select   (mux_select),
        .unit_operand (unit_operand),
        .unit_start   (unit_start),
        .unit_done    (unit_done),
        .unit_result  (unit_result),
        .resp_valid   (resp_valid),
        .resp_id      (resp_id),
        .resp_data    (resp_data),
        .resp_ready   (resp_ready),
        .busy         (busy),
        .err          (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic         v0;
        logic         v1;
        logic [W-1:0] d0;
        logic [W-1:0] d1;
        logic [W-1:0] res;
        int           done_lat;  // WAIT cycle (1-based) in which done pulses
        int           bp;        // RESP cycles with resp_ready held low
        logic         spur;      // pulse done in the accept and START cycles
        logic         exp_id;    // expected winner
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // 1 time unit later, well away from the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        req_0_valid = 1'b0;
        req_1_valid = 1'b0;
        req_0_data  = '0;
        req_1_data  = '0;
        unit_done   = 1'b0;
        unit_result = '0;
        resp_ready  = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  32'(busy), 0);
        check({tag, "_rv"},    32'(resp_valid), 0);
        check({tag, "_start"}, 32'(unit_start), 0);
        check({tag, "_mux"},   32'(mux_select), 0);
        check({tag, "_oper"},  32'(unit_operand), 0);
        check({tag, "_rid"},   32'(resp_id), 0);
        check({tag, "_rdata"}, 32'(resp_data), 0);
        check({tag, "_err"},   32'(err), 0);
        check({tag, "_rdy0"},  32'(req_0_ready), 0);
        check({tag, "_rdy1"},  32'(req_1_ready), 0);
    endtask

    // One complete transaction from a table record, checked cycle by cycle.
    task automatic run_txn(input vec_t v, input int idx);
        logic [W-1:0] exp_op;
        string        t;
        t      = $sformatf("v%0d", idx);
        exp_op = v.exp_id ? v.d1 : v.d0;

        // accept cycle
        tick();
        req_0_valid = v.v0;
        req_1_valid = v.v1;
        req_0_data  = v.d0;
        req_1_data  = v.d1;
        unit_done   = v.spur;
        unit_result = 27'h5A5A5A5;
        resp_ready  = 1'b0;
        settle();
        check({t, "_acc_busy"}, 32'(busy), 0);
        check({t, "_acc_rdy0"}, 32'(req_0_ready), 32'(v.exp_id == 1'b0));
        check({t, "_acc_rdy1"}, 32'(req_1_ready), 32'(v.exp_id == 1'b1));

        // START
        tick();
        req_0_valid = 1'b0;
        req_1_valid = 1'b0;
        unit_done   = v.spur;
        settle();
        check({t, "_st_start"}, 32'(unit_start), 1);
        check({t, "_st_mux"},   32'(mux_select), 32'(v.exp_id));
        check({t, "_st_oper"},  32'(unit_operand), 32'(exp_op));
        check({t, "_st_rdy"},   32'({req_1_ready, req_0_ready}), 0);

        // WAIT
        for (int k = 0; k < v.done_lat; k++) begin
            tick();
            unit_done   = (k == v.done_lat - 1);
            unit_result = (k == v.done_lat - 1) ? v.res : 27'h2AAAAAA;
            settle();
            check({t, "_wt_start"}, 32'(unit_start), 0);
            check({t, "_wt_rv"},    32'(resp_valid), 0);
            check({t, "_wt_busy"},  32'(busy), 1);
            check({t, "_wt_mux"},   32'(mux_select), 32'(v.exp_id));
            check({t, "_wt_oper"},  32'(unit_operand), 32'(exp_op));
        end

        // RESP, with optional backpressure; both valids raised to prove that
        // nothing is granted before the handshake completes.
        for (int k = 0; k <= v.bp; k++) begin
            tick();
            unit_done   = 1'b0;
            resp_ready  = (k == v.bp);
            req_0_valid = 1'b1;
            req_1_valid = 1'b1;
            settle();
            check({t, "_rs_rv"},    32'(resp_valid), 1);
            check({t, "_rs_rid"},   32'(resp_id), 32'(v.exp_id));
            check({t, "_rs_rdata"}, 32'(resp_data), 32'(v.res));
            check({t, "_rs_mux"},   32'(mux_select), 32'(v.exp_id));
            check({t, "_rs_rdy"},   32'({req_1_ready, req_0_ready}), 0);
            check({t, "_rs_err"},   32'(err), 0);
        end
    endtask

    // Reference model state for the randomized phase: at most one job in
    // flight, described by how many cycles ago it was accepted.
    bit           m_active;
    int           m_age;
    int           m_wait_n;
    bit           m_have;
    bit           m_id;
    logic [W-1:0] m_res;
    bit           m_last;
    bit           m_mux;
    logic [W-1:0] m_op;
    bit           m_err;

    initial begin
        int   n_wait;
        bit   g_ok;
        bit   g_id;

        tbl[0] = '{1'b1, 1'b0, 27'h0ABCDEF, 27'h0000000, 27'h1234567, 2, 0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 27'h0000001, 27'h0000002, 27'h0000111, 1, 0, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 27'h0000001, 27'h0000002, 27'h0000222, 1, 0, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 27'h0000001, 27'h0000002, 27'h0000333, 3, 0, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 1'b1, 27'h0000001, 27'h0000002, 27'h0000444, 1, 5, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 27'h0000000, 27'h5555555, 27'h7654321, 2, 0, 1'b1, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 27'h0000000, 27'h0000010, 27'h7FFFFFE, 1, 0, 1'b0, 1'b1};
        tbl[7] = '{1'b1, 1'b1, 27'h7FFFFFF, 27'h0000000, 27'h0F0F0F0, 1, 0, 1'b0, 1'b0};

        idle_inputs();
        rst_n = 1'b0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // a done pulse while idle must be ignored
        tick();
        unit_done = 1'b1;
        settle();
        tick();
        unit_done = 1'b0;
        settle();
        check("idle_done_busy", 32'(busy), 0);
        check("idle_done_rv",   32'(resp_valid), 0);

        foreach (tbl[i]) run_txn(tbl[i], i);

        // Reset during WAIT: requester 1 owns the unit, priority points at 1
        tick();
        req_0_valid = 1'b0;
        req_1_valid = 1'b1;
        req_1_data  = 27'h0333333;
        resp_ready  = 1'b0;
        settle();
        check("rst_acc_rdy1", 32'(req_1_ready), 1);
        tick();
        req_1_valid = 1'b0;
        settle();
        check("rst_st_mux", 32'(mux_select), 1);
        tick();
        settle();
        check("rst_wait_busy", 32'(busy), 1);
        tick();
        rst_n = 1'b0;
        settle();
        check_all_zero("midrst");
        tick();
        rst_n       = 1'b1;
        unit_done   = 1'b1;
        unit_result = 27'h3FFFFFF;
        settle();
        for (int k = 0; k < 3; k++) begin
            tick();
            unit_done = 1'b0;
            settle();
            check("late_done_rv",   32'(resp_valid), 0);
            check("late_done_busy", 32'(busy), 0);
        end
        // priority pointer is back at its reset value: requester 0 wins
        run_txn('{1'b1, 1'b1, 27'h0000AAA, 27'h0000BBB, 27'h0000CCC, 1, 0, 1'b0, 1'b0}, 8);

`ifdef FPA_TIMEOUT_EN
        // Watchdog: never pulse done; expect exactly TO WAIT cycles
        tick();
        req_0_valid = 1'b1;
        req_1_valid = 1'b0;
        req_0_data  = 27'h0000077;
        resp_ready  = 1'b0;
        unit_done   = 1'b0;
        settle();
        check("to_acc_rdy0", 32'(req_0_ready), 1);
        tick();
        req_0_valid = 1'b0;
        settle();
        check("to_start", 32'(unit_start), 1);
        n_wait = 0;
        for (int k = 0; k < 4 * TO; k++) begin
            tick();
            settle();
            if (resp_valid) break;
            n_wait++;
        end
        check("to_wait_cycles", 32'(n_wait), 32'(TO));
        check("to_err",   32'(err), 1);
        check("to_rv",    32'(resp_valid), 1);
        check("to_rdata", 32'(resp_data), 32'(27'h7FFFFFF));
        check("to_rid",   32'(resp_id), 0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        settle();
        check("to_idle_busy", 32'(busy), 0);
        check("to_err_sticky", 32'(err), 1);
`endif

        // Randomized phase from a fresh reset
        idle_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m_active = 0; m_age = 0; m_wait_n = 0; m_have = 0; m_id = 0;
        m_res = '0; m_last = 1; m_mux = 0; m_op = '0; m_err = 0;

        for (int c = 0; c < N_RANDOM; c++) begin
            tick();
            req_0_valid = ($urandom_range(0, 9) < 6);
            req_1_valid = ($urandom_range(0, 9) < 6);
            req_0_data  = W'($urandom);
            req_1_data  = W'($urandom);
            unit_done   = ($urandom_range(0, 3) == 0);
            unit_result = W'($urandom);
            resp_ready  = ($urandom_range(0, 1) == 1);
            settle();

            // who would be served if the unit were free this cycle
            g_ok = req_0_valid || req_1_valid;
            g_id = (req_0_valid && req_1_valid) ? !m_last : req_1_valid;

            check("rnd_rdy0",  32'(req_0_ready), 32'(!m_active && g_ok && !g_id));
            check("rnd_rdy1",  32'(req_1_ready), 32'(!m_active && g_ok && g_id));
            check("rnd_start", 32'(unit_start), 32'(m_active && m_age == 1));
            check("rnd_rv",    32'(resp_valid), 32'(m_active && m_have));
            check("rnd_busy",  32'(busy), 32'(m_active));
            check("rnd_mux",   32'(mux_select), 32'(m_mux));
            check("rnd_oper",  32'(unit_operand), 32'(m_op));
            check("rnd_err",   32'(err), 32'(m_err));
            if (m_active && m_have) begin
                check("rnd_rid",   32'(resp_id), 32'(m_id));
                check("rnd_rdata", 32'(resp_data), 32'(m_res));
            end

            // advance the model across the coming edge
            if (!m_active) begin
                if (g_ok) begin
                    m_active = 1;
                    m_age    = 1;
                    m_id     = g_id;
                    m_mux    = g_id;
                    m_op     = g_id ? req_1_data : req_0_data;
                end
            end else if (m_age == 1) begin
                m_age    = 2;
                m_wait_n = 0;
            end else if (!m_have) begin
                if (unit_done) begin
                    m_have = 1;
                    m_res  = unit_result;
                end
`ifdef FPA_TIMEOUT_EN
                else if (m_wait_n == TO - 1) begin
                    m_have = 1;
                    m_res  = '1;
                    m_err  = 1;
                end else begin
                    m_wait_n++;
                end
`endif
            end else if (resp_ready) begin
                m_active = 0;
                m_have   = 0;
                m_last   = m_id;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fp_mux_share_arbiter.md
Name: fp_mux_share_arbiter

Overview:
- Shares one multi-cycle floating-point mantissa unit between two requesters.
- The unit's 27-bit operand input is fed through a 2:1 27-bit operand mux.
- This block arbitrates round-robin, latches the winning operand and drives the mux select.
- It pulses the unit start, waits for done and returns the 27-bit result tagged with the requester id.

Parameters:
- WIDTH, 27, operand/result width (mantissa plus guard/round/sticky).
- TIMEOUT, 64, watchdog limit in cycles; used only with FPA_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_0_valid  in  1  requester 0 has an operand.
- req_0_data  in  WIDTH  requester 0 operand.
- req_0_ready  out  1  one-cycle accept pulse to requester 0.
- req_1_valid  in  1  requester 1 has an operand.
- req_1_data  in  WIDTH  requester 1 operand.
- req_1_ready  out  1  one-cycle accept pulse to requester 1.
- mux_select  out  1  operand mux select (0 = requester 0 path, 1 = requester 1 path).
- unit_operand  out  WIDTH  registered operand to the shared unit.
- unit_start  out  1  one-cycle start pulse to the shared unit.
- unit_done  in  1  unit result valid (single-cycle pulse).
- unit_result  in  WIDTH  unit result.
- resp_valid  out  1  response available.
- resp_id  out  1  id of the requester that owns the response.
- resp_data  out  WIDTH  response data.
- resp_ready  in  1  consumer accepts the response.
- busy  out  1  high in every state except IDLE.
- err  out  1  timeout flag; constant 0 without FPA_TIMEOUT_EN.

Behaviour:
- Reset (rst_n low, async): state IDLE. All outputs 0, including mux_select, unit_operand, resp_id and resp_data. Priority pointer last_grant=1, so requester 0 wins the first tie.
- IDLE:
  - No valid: stay in IDLE.
  - Exactly one valid: grant it.
  - Both valid: grant the requester not equal to last_grant.
  - On a grant, in the same cycle: assert req_N_ready (combinational from state and valids), latch req_N_data into the operand register, latch id into the grant register, go to START.
- START (1 cycle): unit_start=1, unit_operand=latched operand, mux_select=grant id. Go to WAIT.
- WAIT:
  - mux_select and unit_operand are held.
  - unit_done is sampled only in WAIT; any unit_done seen in IDLE or START is ignored.
  - On unit_done=1: latch unit_result into resp_data, set resp_id=grant, go to RESP.
- RESP:
  - resp_valid=1; resp_data and resp_id are held stable until accepted.
  - When resp_valid and resp_ready are both high, the response transfers: last_grant <= grant, go to IDLE.
  - A new request can be granted no earlier than the cycle after the transfer.
- Minimum latency, request accept to resp_valid: 3 cycles (accept, START, done in the first WAIT cycle, RESP).
- mux_select holds its last value in IDLE. It never changes between START and the RESP handshake.
- A valid dropped by a requester before its ready pulse is not latched and not remembered.
- The non-granted requester's valid is held pending. It wins the next arbitration if still asserted.
- Reset mid-operation: immediate return to IDLE with all outputs cleared. A late unit_done after reset is ignored because the block is not in WAIT.

Optional Feature:
- Macro: FPA_TIMEOUT_EN.
- Defined:
  - A counter clears on entering WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT-1 without unit_done: set err=1 (sticky until reset), go to RESP with resp_data=all-ones and resp_id=grant.
  - Completion then follows the normal RESP handshake.
- Undefined: no counter logic; err tied 0; WAIT waits indefinitely.

Test Plan:
- Single request: req_0_valid=1, data=27'h0ABCDEF; unit_done 2 cycles after start with result 27'h1234567 -> req_0_ready pulses once; unit_start pulses once; mux_select=0; resp_valid with resp_id=0, resp_data=27'h1234567.
- Contention: both valid continuously, data 27'h0000001 and 27'h0000002 -> grants alternate 0,1,0,1; resp_id sequence 0,1,0,1; each ready pulses once per grant.
- Response backpressure: resp_ready low for 5 cycles in RESP -> resp_valid, resp_data and resp_id stable. No new ready pulse until the cycle after the handshake.
- Spurious done: unit_done pulsed in IDLE and in START -> ignored. The block stays waiting for the done in WAIT.
- Reset mid-WAIT: rst_n low for 1 cycle, then unit_done pulses -> all outputs 0, resp_valid never asserted, next grant goes to requester 0.
- FPA_TIMEOUT_EN, TIMEOUT=8: no unit_done -> after 8 WAIT cycles err=1, resp_valid=1, resp_data=27'h7FFFFFF.
